// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC transmit arbiter.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  localparam int unsigned IFG_N_DEF = 12;

endpackage

// File: rtl/rr_arb.sv
// Combinational rotating-priority selector: the search starts one past ptr and wraps,
// so ptr = REQ_N-1 degenerates to lowest-index-wins.
module rr_arb #(
  parameter int unsigned REQ_N = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [REQ_N-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ_N-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(REQ_N); k++) begin
      idx = PTR_W'((32'(ptr) + 32'(k)) % REQ_N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-level arbiter muxing REQ_N beat streams onto one MAC TX port with an inter-frame gap.
// Define MAC_TX_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned REQ_N  = 2,
  parameter  int unsigned IFG_N  = IFG_N_DEF,
  localparam int unsigned LEN_W  = $clog2(DATA_W / 8 + 1),
  localparam int unsigned BPC    = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REQ_N-1:0]        req_valid_i,
  input  logic [REQ_N*DATA_W-1:0] req_data_i,
  input  logic [REQ_N*LEN_W-1:0]  req_len_i,
  input  logic [REQ_N-1:0]        req_term_i,
  output logic [REQ_N-1:0]        req_ready_o,
  input  logic                    cancel_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    start_o,
  output logic                    term_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  output logic [REQ_N-1:0]        grant_o
);

  localparam int unsigned PTR_W    = $clog2(REQ_N);
  localparam int unsigned GAP_CYC  = (IFG_N + BPC - 1) / BPC;
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e             state, state_nxt;
  logic [REQ_N-1:0]   grant, grant_nxt, arb_gnt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, arb_ptr, owner_idx;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               first, first_nxt;
  logic [LEN_W-1:0]   len_sel;
  logic               accept, frame_end;

`ifdef MAC_TX_ARB_STRICT_PRIO_EN
  assign arb_ptr = PTR_W'(REQ_N - 1);
`else
  assign arb_ptr = ptr;
`endif

  rr_arb #(
    .REQ_N(REQ_N),
    .PTR_W(PTR_W)
  ) u_rr_arb (
    .req(req_valid_i),
    .ptr(arb_ptr),
    .gnt(arb_gnt)
  );

  // grant is all-zero outside XFER, so every muxed output falls to 0 there (and in reset).
  always_comb begin
    data_o    = '0;
    len_sel   = '0;
    owner_idx = '0;
    for (int i = 0; i < int'(REQ_N); i++) begin
      if (grant[i]) begin
        data_o    = req_data_i[i*DATA_W +: DATA_W];
        len_sel   = req_len_i[i*LEN_W +: LEN_W];
        owner_idx = PTR_W'(i);
      end
    end
  end

  assign grant_o     = grant;
  assign valid_o     = |(req_valid_i & grant);
  assign term_o      = |(req_term_i & grant);
  assign start_o     = first & valid_o;
  assign len_o       = (grant == '0) ? '0 : (term_o ? len_sel : LEN_W'(BPC));
  assign req_ready_o = grant & {REQ_N{ready_i & ~cancel_i}};
  assign accept      = valid_o & ready_i & ~cancel_i;
  assign frame_end   = cancel_i | (accept & term_o);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    gap_nxt   = gap_cnt;
    first_nxt = first;
    unique case (state)
      IDLE: begin
        if (|req_valid_i) begin
          state_nxt = XFER;
          grant_nxt = arb_gnt;
          first_nxt = 1'b1;
        end
      end
      XFER: begin
        if (frame_end) begin
          state_nxt = GAP;
          grant_nxt = '0;
          ptr_nxt   = owner_idx;
          gap_nxt   = GAP_W'(GAP_LOAD);
          first_nxt = 1'b1;
        end else if (accept) begin
          first_nxt = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= PTR_W'(REQ_N - 1);
      gap_cnt <= '0;
      first   <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      gap_cnt <= gap_nxt;
      first   <= first_nxt;
    end
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Self-checking bench for mac_tx_arb: directed vector table, corner sequences and random
// traffic against a frame-level reference model. Honours MAC_TX_ARB_STRICT_PRIO_EN.
module tb_mac_tx_arb;

  localparam int DW = 16, N = 2, IFG = 12, BPC = 2, LW = 2, GAP_CYC = 6;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_term = '0, req_ready, grant;
  logic [N*DW-1:0] req_data = '0;
  logic [N*LW-1:0] req_len = '0;
  logic            cancel = 1'b0, ready = 1'b0, valid, start, term;
  logic [DW-1:0]   data;
  logic [LW-1:0]   len;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  mac_tx_arb #(.DATA_W(DW), .REQ_N(N), .IFG_N(IFG)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_len_i(req_len), .req_term_i(req_term), .req_ready_o(req_ready),
    .cancel_i(cancel), .ready_i(ready), .valid_o(valid), .start_o(start), .term_o(term),
    .data_o(data), .len_o(len), .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: who owns the bus, whether the next offered beat opens the frame,
  // how many gap cycles remain, and who owned last.
  int m_mode, m_own, m_last, m_gap;
  bit m_first;

  function automatic int pick(input logic [N-1:0] v);
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_own <= -1; m_last <= N - 1; m_gap <= 0; m_first <= 1'b1;
    end else begin
      case (m_mode)
        0: if (req_valid != '0) begin
          m_own <= pick(req_valid); m_mode <= 1; m_first <= 1'b1;
        end
        1: begin
          if (cancel || (req_valid[m_own] && ready && req_term[m_own])) begin
            m_last <= m_own; m_own <= -1; m_mode <= 2; m_gap <= GAP_CYC; m_first <= 1'b1;
          end else if (req_valid[m_own] && ready) begin
            m_first <= 1'b0;
          end
        end
        default: begin
          m_gap <= m_gap - 1;
          if (m_gap == 1) m_mode <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic ev, es, et;
    logic [LW-1:0] el;
    logic [DW-1:0] ed;
    if (chk_en) begin
      eg = '0; er = '0; ev = 1'b0; es = 1'b0; et = 1'b0; el = '0; ed = '0;
      if (!reset && m_mode == 1) begin
        eg = N'(1) << m_own;
        ev = req_valid[m_own];
        es = m_first && ev;
        et = req_term[m_own];
        el = et ? req_len[m_own*LW +: LW] : LW'(BPC);
        ed = req_data[m_own*DW +: DW];
        er = (ready && !cancel) ? eg : '0;
      end
      chk("model_grant", grant, eg);
      chk("model_valid", valid, ev);
      chk("model_start", start, es);
      chk("model_term", term, et);
      chk("model_len", len, el);
      chk("model_data", data, ed);
      chk("model_ready", req_ready, er);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req_valid = '0; req_term = '0; cancel = 1'b0; ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] v, t, l0;
    logic [15:0] d0;
    logic rdy;
    logic [1:0] eg;
    logic ev, es, et;
    logic [1:0] el;
    logic [15:0] ed;
    logic [1:0] er;
  } vec_t;

  vec_t tbl[13];
  logic [1:0] exp2[4];
  logic [1:0] got[$];
  int idle_cyc;
  bit seen, r1_leak;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1 as a cycle table: 3-beat frame from req0, 6 gap cycles, then a re-grant.
    tbl[0] = '{2'b01, 2'b00, 2'd0, 16'h1111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00};
    tbl[1] = '{2'b01, 2'b00, 2'd0, 16'hA001, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 2'd2, 16'hA001, 2'b01};
    tbl[2] = '{2'b01, 2'b00, 2'd0, 16'hA002, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'd2, 16'hA002, 2'b01};
    tbl[3] = '{2'b01, 2'b01, 2'd1, 16'hA003, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 2'd1, 16'hA003, 2'b01};
    for (int r = 4; r <= 10; r++)
      tbl[r] = '{2'b01, 2'b00, 2'd0, 16'hEE00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00};
    tbl[11] = '{2'b01, 2'b01, 2'd2, 16'hB00B, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 16'hB00B, 2'b01};
    tbl[12] = '{2'b00, 2'b00, 2'd0, 16'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 2'b00};
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    exp2 = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp2 = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    chk_en = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    for (int r = 0; r < 13; r++) begin
      req_valid = tbl[r].v; req_term = tbl[r].t; ready = tbl[r].rdy;
      req_len = {2'd2, tbl[r].l0}; req_data = {16'h5555, tbl[r].d0};
      @(negedge clk);
      chk($sformatf("t%0d_grant", r), grant, tbl[r].eg);
      chk($sformatf("t%0d_valid", r), valid, tbl[r].ev);
      chk($sformatf("t%0d_start", r), start, tbl[r].es);
      chk($sformatf("t%0d_term", r), term, tbl[r].et);
      chk($sformatf("t%0d_len", r), len, tbl[r].el);
      chk($sformatf("t%0d_data", r), data, tbl[r].ed);
      chk($sformatf("t%0d_ready", r), req_ready, tbl[r].er);
      step();
    end

    // Scenario 2/3: both requesters hold 1-beat frames.
    do_reset();
    req_valid = 2'b11; req_term = 2'b11; req_len = {2'd2, 2'd2}; ready = 1'b1;
    req_data = {16'h2222, 16'h1111};
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      @(negedge clk);
      if (valid && ready) got.push_back(grant);
      step();
    end
    chk("s2_frames", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("s2_grant%0d", i), got[i], exp2[i]);

    // Scenario 4: first beat stalled by ready low for 3 cycles.
    do_reset();
    req_valid = 2'b01; req_term = 2'b00; ready = 1'b0; req_data = {16'h0, 16'hC0DE};
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s4_start_held", start, 1'b1);
      chk("s4_data_held", data, 16'hC0DE);
      chk("s4_ready_low", req_ready, 2'b00);
      step();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("s4_accept_ready", req_ready, 2'b01);
    step();
    @(negedge clk);
    chk("s4_start_drop", start, 1'b0);
    req_term = 2'b01;
    step();

    // Scenario 5: cancel on beat 2 of a req1 frame while req0 waits.
    do_reset();
    req_valid = 2'b10; req_term = 2'b00; ready = 1'b1; req_data = {16'hD1D1, 16'hD0D0};
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("s5_grant1", grant, 2'b10);
    chk("s5_beat1_ready", req_ready, 2'b10);
    step();
    cancel = 1'b1;
    @(negedge clk);
    chk("s5_cancel_ready", req_ready, 2'b00);
    step();
    cancel = 1'b0;
    idle_cyc = 0; seen = 1'b0; r1_leak = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[1]) r1_leak = 1'b1;
      if (grant != '0) seen = 1'b1;
      else idle_cyc++;
      if (!seen) step();
    end
    chk("s5_regrant_seen", seen, 1'b1);
    chk("s5_gap_len", idle_cyc, GAP_CYC + 1);
    chk("s5_next_owner", grant, 2'b01);
    chk("s5_no_req1_beat", r1_leak, 1'b0);
    step();

    // Scenario 6: asynchronous reset mid-frame, then req1 alone.
    do_reset();
    req_valid = 2'b01; req_term = 2'b00; ready = 1'b0; req_data = {16'h6161, 16'h6060};
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("s6_rst_grant", grant, 2'b00);
    chk("s6_rst_valid", valid, 1'b0);
    chk("s6_rst_start", start, 1'b0);
    chk("s6_rst_data", data, 16'h0);
    chk("s6_rst_len", len, 2'd0);
    chk("s6_rst_ready", req_ready, 2'b00);
    req_valid = 2'b10;
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("s6_grant_req1", grant, 2'b10);
    step();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom);
      req_term = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      req_len = LW * N'($urandom);
      req_len = (N*LW)'($urandom);
      req_data = (N*DW)'($urandom);
      ready = ($urandom_range(3) != 0);
      cancel = ($urandom_range(19) == 0);
      step();
    end
    req_valid = '0; cancel = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arb.md
MAC_TX_ARB -- requirements
Module: mac_tx_arb

Interface
REQ-001 Parameter DATA_W, default 16: data bus width in bits; legal values 16, 32 and 64.
REQ-002 Parameter REQ_N, default 2: number of frame requesters; legal range 2..4.
REQ-003 Parameter IFG_N, default 12: inter-frame gap in bytes.
REQ-004 Derived LEN_W = clog2(DATA_W/8+1); derived BPC = DATA_W/8 bytes per cycle.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i  in  REQ_N  per-requester beat valid.
REQ-008 req_data_i  in  REQ_N*DATA_W  per-requester data; requester i occupies slice i.
REQ-009 req_len_i  in  REQ_N*LEN_W  per-requester valid byte count; only meaningful when term is set.
REQ-010 req_term_i  in  REQ_N  per-requester last beat of frame.
REQ-011 req_ready_o  out  REQ_N  per-requester beat accepted this cycle.
REQ-012 cancel_i  in  1  MAC aborts the current frame.
REQ-013 ready_i  in  1  MAC TX able to accept a beat.
REQ-014 valid_o / start_o / term_o  out  1 each  beat valid, first beat of frame, last beat of frame.
REQ-015 data_o  out  DATA_W; len_o  out  LEN_W: muxed beat data and byte count.
REQ-016 grant_o  out  REQ_N  one-hot current owner; all-zero when no requester owns the bus.

Function
REQ-017 FSM states: IDLE, XFER, GAP; exactly one state is active at any time.
REQ-018 IDLE: if any req_valid_i bit is set, the arbiter selects one requester and moves to XFER in the next cycle with grant_o registered; otherwise it stays in IDLE.
REQ-019 Default selection is round-robin: the search starts at the requester after the last owner, wrapping from REQ_N-1 to 0.
REQ-020 Latency: a request seen in IDLE at cycle t gives grant_o at t+1; the first beat can be accepted at t+1.
REQ-021 In XFER: valid_o = req_valid_i[g] and req_ready_o[g] = ready_i; every non-granted ready bit is 0.
REQ-022 A beat is accepted when valid_o and ready_i are both 1.
REQ-023 start_o is 1 only on the first beat offered after a grant; it is held until that beat is accepted.
REQ-024 term_o = req_term_i[g]; len_o = req_len_i[g] on a term beat and BPC otherwise.
REQ-025 Ownership never changes mid-frame; a non-granted requester stalls indefinitely.
REQ-026 Acceptance of a term beat moves the FSM to GAP and updates the round-robin pointer to g.
REQ-027 GAP lasts ceil(IFG_N/BPC) cycles, counted by a down-counter; valid_o = 0 and grant_o = 0 during GAP.
REQ-028 When the gap counter reaches 0, the FSM returns to IDLE; a request already pending is granted in the following cycle.
REQ-029 cancel_i in XFER: move to GAP in the next cycle, drop ownership and update the pointer.
REQ-030 cancel_i in XFER: req_ready_o[g] is forced to 0 in the cancel cycle.
REQ-031 cancel_i in IDLE or GAP is ignored.
REQ-032 If cancel_i and a term acceptance occur in the same cycle, the frame is treated as cancelled; the resulting behaviour is identical.
REQ-033 With REQ_N requesters continuously valid, every requester is granted within REQ_N frames.

Reset
REQ-034 While reset is asserted, and immediately after it deasserts: state = IDLE, pointer = REQ_N-1 (so requester 0 wins first), gap counter = 0, first-beat flag = 1.
REQ-035 While reset is asserted: all outputs = 0, including grant_o, valid_o, start_o, term_o, len_o, data_o and req_ready_o.
REQ-036 Reset mid-frame discards the frame without emitting a term beat.

Configuration
REQ-037 Macro MAC_TX_ARB_STRICT_PRIO_EN defined: selection is fixed priority, lowest index wins, and the pointer is unused.
REQ-038 Macro MAC_TX_ARB_STRICT_PRIO_EN undefined: round-robin selection per REQ-019.

Structure
REQ-039 Shared package mac_pkg holds the FSM state enum (IDLE, XFER, GAP) and the IFG_N default constant.
REQ-040 Requester selection is implemented in sub-module rr_arb (request vector and pointer in, one-hot grant out, combinational); the FSM, gap counter and datapath mux stay in mac_tx_arb.

Verification
REQ-041 Scenario 1: req0 sends a 3-beat frame, ready_i = 1, DATA_W = 16 -> grant_o = 01 one cycle later; start_o on beat 1; term_o with len_o = 1 on beat 3; 6 GAP cycles; then IDLE.
REQ-042 Scenario 2: req0 and req1 continuously valid, 1-beat frames -> grants alternate 01, 10, 01, 10.
REQ-043 Scenario 3: repeat scenario 2 with MAC_TX_ARB_STRICT_PRIO_EN defined -> grant_o = 01 for every frame.
REQ-044 Scenario 4: ready_i = 0 for 3 cycles on the first beat -> start_o and data_o held stable; req_ready_o = 0 throughout the stall.
REQ-045 Scenario 5: cancel_i on beat 2 of a 4-beat frame from req1 -> no further beats from req1; GAP entered; req0 (pending) granted next.
REQ-046 Scenario 6: reset asserted mid-XFER -> all outputs 0 asynchronously; after release, req1 alone pending -> grant_o = 10 one cycle later.
